// File: rtl/vme_interrupter.sv
// vme_interrupter: VME D08(O) interrupter -- raises one IRQ level, answers its IACK cycle, passes others down the chain
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   local_req, local_vector       request pulse and the status/ID vector sampled with it
//   local_clear                   register-access clear (RORA build only)
//   local_busy, local_ack         request outstanding; one-cycle pulse once the vector is delivered
//   vme_irq_n                     IRQ7*..IRQ1*, only bit [IRQ_LEVEL-1] is ever driven low
//   vme_iack_n, vme_iackin_n      IACK* and daisy-chain IACKIN*
//   vme_iackout_n                 daisy-chain IACKOUT*
//   vme_as_n, vme_ds0_n           address and data strobes
//   vme_addr                      A3..A1, level being acknowledged
//   vme_data, vme_data_oe         vector D7..D0 and its buffer enable
//   vme_dtack_n                   DTACK*
// Define VME_INTR_RORA_EN for release-on-register-access; the default build is release-on-acknowledge.
module vme_interrupter #(
    parameter logic [2:0] IRQ_LEVEL   = 3'd2,
    parameter int         DTACK_DELAY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       local_req,
    input  logic [7:0] local_vector,
    input  logic       local_clear,
    output logic       local_busy,
    output logic       local_ack,
    output logic [6:0] vme_irq_n,
    input  logic       vme_iack_n,
    input  logic       vme_iackin_n,
    output logic       vme_iackout_n,
    input  logic       vme_as_n,
    input  logic       vme_ds0_n,
    input  logic [2:0] vme_addr,
    output logic [7:0] vme_data,
    output logic       vme_data_oe,
    output logic       vme_dtack_n
);
    typedef enum logic [2:0] {IDLE, PENDING, PASS, RESPOND, DONE, HELD} state_t;
    localparam logic [6:0] IRQ_BIT = 7'd1 << (IRQ_LEVEL - 3'd1);
    localparam logic [7:0] DLY     = 8'(DTACK_DELAY);
    state_t     state, state_nx, ret, ret_nx;
    logic [7:0] vec, vec_nx, cnt, cnt_nx;
    logic       busy, busy_nx, irq_on, irq_nx;
    logic [1:0] iack_sy, iackin_sy, as_sy, ds_sy;
    logic       as_s, qual, match;
`ifndef VME_INTR_RORA_EN
    logic unused_clear;
    assign unused_clear = local_clear;
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            iack_sy   <= 2'b11;
            iackin_sy <= 2'b11;
            as_sy     <= 2'b11;
            ds_sy     <= 2'b11;
        end else begin
            iack_sy   <= {iack_sy[0], vme_iack_n};
            iackin_sy <= {iackin_sy[0], vme_iackin_n};
            as_sy     <= {as_sy[0], vme_as_n};
            ds_sy     <= {ds_sy[0], vme_ds0_n};
        end
    assign as_s  = as_sy[1];
    assign qual  = ~(as_s | iack_sy[1] | iackin_sy[1] | ds_sy[1]);
    assign match = vme_addr == IRQ_LEVEL;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state  <= IDLE;
            ret    <= IDLE;
            vec    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            irq_on <= 1'b0;
        end else begin
            state  <= state_nx;
            ret    <= ret_nx;
            vec    <= vec_nx;
            cnt    <= cnt_nx;
            busy   <= busy_nx;
            irq_on <= irq_nx;
        end
    // ret remembers where a pass-through cycle resumes, so a pending request survives foreign IACK cycles
    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        vec_nx   = vec;
        cnt_nx   = '0;
        busy_nx  = busy;
        irq_nx   = irq_on;
        case (state)
            IDLE: begin
                if (local_req) begin
                    vec_nx   = local_vector;
                    busy_nx  = 1'b1;
                    irq_nx   = 1'b1;
                    state_nx = PENDING;
                end
                // a cycle already under way belongs downstream, even if a request lands with it
                if (qual) begin
                    ret_nx   = local_req ? PENDING : IDLE;
                    state_nx = PASS;
                end
            end
            PENDING, HELD: if (qual) begin
                if (match) begin
                    state_nx = RESPOND;
`ifndef VME_INTR_RORA_EN
                    irq_nx   = 1'b0;
`endif
                end else begin
                    ret_nx   = state;
                    state_nx = PASS;
                end
            end
            PASS: if (as_s) state_nx = ret;
            RESPOND: begin
                cnt_nx = (cnt == DLY) ? cnt : cnt + 8'd1;
                if (as_s | ds_sy[1]) state_nx = DONE;
            end
            DONE: begin
`ifdef VME_INTR_RORA_EN
                state_nx = HELD;
`else
                state_nx = IDLE;
                busy_nx  = 1'b0;
`endif
            end
            default: state_nx = IDLE;
        endcase
`ifdef VME_INTR_RORA_EN
        if (state == HELD && local_clear) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            irq_nx   = 1'b0;
        end
`endif
    end
    assign local_busy    = busy;
    assign local_ack     = state == DONE;
    assign vme_irq_n     = irq_on ? ~IRQ_BIT : 7'h7F;
    assign vme_iackout_n = ~(state == PASS && !as_s);
    assign vme_data_oe   = state == RESPOND;
    assign vme_data      = vme_data_oe ? vec : '0;
    assign vme_dtack_n   = ~(vme_data_oe && cnt == DLY);
endmodule

// File: tb/tb_vme_interrupter.sv
// tb_vme_interrupter: scoreboard bench for vme_interrupter at IRQ level 2, DTACK delay 1
module tb_vme_interrupter;
    localparam logic [2:0] LVL = 3'd2;
    localparam int         DLY = 1;
`ifdef VME_INTR_RORA_EN
    localparam logic [6:0] IRQ_POST  = 7'h7D;
    localparam logic       BUSY_POST = 1'b1;
`else
    localparam logic [6:0] IRQ_POST  = 7'h7F;
    localparam logic       BUSY_POST = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       local_req = 1'b0;
    logic [7:0] local_vector = '0;
    logic       local_clear = 1'b0;
    logic       local_busy, local_ack;
    logic [6:0] vme_irq_n;
    logic       vme_iack_n = 1'b1;
    logic       vme_iackin_n = 1'b1;
    logic       vme_iackout_n;
    logic       vme_as_n = 1'b1;
    logic       vme_ds0_n = 1'b1;
    logic [2:0] vme_addr = '0;
    logic [7:0] vme_data;
    logic       vme_data_oe, vme_dtack_n;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    vme_interrupter #(.IRQ_LEVEL(LVL), .DTACK_DELAY(DLY)) dut (
        .clock(clk), .reset(rst),
        .local_req(local_req), .local_vector(local_vector), .local_clear(local_clear),
        .local_busy(local_busy), .local_ack(local_ack),
        .vme_irq_n(vme_irq_n), .vme_iack_n(vme_iack_n), .vme_iackin_n(vme_iackin_n),
        .vme_iackout_n(vme_iackout_n), .vme_as_n(vme_as_n), .vme_ds0_n(vme_ds0_n),
        .vme_addr(vme_addr), .vme_data(vme_data), .vme_data_oe(vme_data_oe),
        .vme_dtack_n(vme_dtack_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic do_reset;
        rst = 1'b1;
        local_req = 1'b0;
        local_clear = 1'b0;
        vme_iack_n = 1'b1;
        vme_iackin_n = 1'b1;
        vme_as_n = 1'b1;
        vme_ds0_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic request(input logic [7:0] v);
        @(negedge clk);
        local_req = 1'b1;
        local_vector = v;
        @(negedge clk);
        local_req = 1'b0;
    endtask

    task automatic start_iack(input logic [2:0] a);
        @(negedge clk);
        vme_addr = a;
        vme_iack_n = 1'b0;
        vme_iackin_n = 1'b0;
        vme_as_n = 1'b0;
        vme_ds0_n = 1'b0;
    endtask

    task automatic end_iack;
        @(negedge clk);
        vme_iack_n = 1'b1;
        vme_iackin_n = 1'b1;
        vme_as_n = 1'b1;
        vme_ds0_n = 1'b1;
    endtask

    // waits for either DTACK (answered) or IACKOUT (passed); oe_n counts cycles the vector was driven before DTACK
    task automatic wait_resp(output logic hit, output logic pass, output int oe_n, output int w);
        hit = 1'b0;
        pass = 1'b0;
        oe_n = 0;
        w = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            w = i + 1;
            if (vme_iackout_n === 1'b0) begin pass = 1'b1; break; end
            if (vme_dtack_n === 1'b0) begin hit = 1'b1; break; end
            if (vme_data_oe === 1'b1) oe_n++;
        end
    endtask

    task automatic wait_ack(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (local_ack === 1'b1) begin seen = 1'b1; break; end
        end
    endtask

    task automatic wait_release(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vme_iackout_n === 1'b1) begin seen = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (vme_irq_n !== 7'h7F) begin n_bad++; $display("FAIL rst_irq: got %h want 7f", vme_irq_n); end
        n_cmp++; if (vme_iackout_n !== 1'b1) begin n_bad++; $display("FAIL rst_iackout: got %b want 1", vme_iackout_n); end
        n_cmp++; if (vme_dtack_n !== 1'b1) begin n_bad++; $display("FAIL rst_dtack: got %b want 1", vme_dtack_n); end
        n_cmp++; if (vme_data_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", vme_data_oe); end
        n_cmp++; if (vme_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", vme_data); end
        n_cmp++; if (local_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", local_busy); end
        n_cmp++; if (local_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", local_ack); end
        do_reset;
    endtask

    task automatic test_level_match;
        logic hit, pass, seen;
        int oe_n, w;
        logic [7:0] exp;
        request(8'h45);
        exp_q.push_back(8'h45);
        n_cmp++; if (vme_irq_n !== 7'h7D) begin n_bad++; $display("FAIL match_irq_req: got %h want 7d", vme_irq_n); end
        n_cmp++; if (local_busy !== 1'b1) begin n_bad++; $display("FAIL match_busy_req: got %b want 1", local_busy); end
        start_iack(LVL);
        wait_resp(hit, pass, oe_n, w);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL match_dtack: got %b want 1", hit); end
        exp = 8'hxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_cmp++; if (vme_data !== exp) begin n_bad++; $display("FAIL match_data: got %h want %h", vme_data, exp); end
        n_cmp++; if (vme_data_oe !== 1'b1) begin n_bad++; $display("FAIL match_oe: got %b want 1", vme_data_oe); end
        n_cmp++; if (oe_n !== DLY) begin n_bad++; $display("FAIL match_dtack_delay: got %0d want %0d", oe_n, DLY); end
        n_cmp++; if (vme_irq_n !== IRQ_POST) begin n_bad++; $display("FAIL match_irq_resp: got %h want %h", vme_irq_n, IRQ_POST); end
        end_iack;
        wait_ack(seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL match_ack: got %b want 1", seen); end
        n_cmp++; if (vme_dtack_n !== 1'b1) begin n_bad++; $display("FAIL match_dtack_rel: got %b want 1", vme_dtack_n); end
        n_cmp++; if (vme_data_oe !== 1'b0) begin n_bad++; $display("FAIL match_oe_rel: got %b want 0", vme_data_oe); end
        @(negedge clk);
        n_cmp++; if (local_ack !== 1'b0) begin n_bad++; $display("FAIL match_ack_pulse: got %b want 0", local_ack); end
        n_cmp++; if (local_busy !== BUSY_POST) begin n_bad++; $display("FAIL match_busy_post: got %b want %b", local_busy, BUSY_POST); end
        n_cmp++; if (vme_irq_n !== IRQ_POST) begin n_bad++; $display("FAIL match_irq_post: got %h want %h", vme_irq_n, IRQ_POST); end
    endtask

    task automatic test_level_mismatch;
        logic hit, pass, seen;
        int oe_n, w;
        logic [7:0] exp;
        request(8'h45);
        exp_q.push_back(8'h45);
        start_iack(3'd5);
        wait_resp(hit, pass, oe_n, w);
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL mis_pass: got %b want 1", pass); end
        n_cmp++; if (vme_dtack_n !== 1'b1) begin n_bad++; $display("FAIL mis_dtack: got %b want 1", vme_dtack_n); end
        n_cmp++; if (vme_irq_n !== 7'h7D) begin n_bad++; $display("FAIL mis_irq: got %h want 7d", vme_irq_n); end
        end_iack;
        wait_release(seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mis_release: got %b want 1", seen); end
        start_iack(LVL);
        wait_resp(hit, pass, oe_n, w);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL mis_resume: got %b want 1", hit); end
        exp = 8'hxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_cmp++; if (vme_data !== exp) begin n_bad++; $display("FAIL mis_data: got %h want %h", vme_data, exp); end
        end_iack;
        wait_ack(seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mis_ack: got %b want 1", seen); end
    endtask

    task automatic test_idle_pass;
        logic hit, pass, seen;
        int oe_n, w;
        start_iack(3'd3);
        wait_resp(hit, pass, oe_n, w);
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL idle_pass: got %b want 1", pass); end
        n_cmp++; if (w > 3) begin n_bad++; $display("FAIL idle_latency: got %0d want <=3", w); end
        n_cmp++; if (vme_data_oe !== 1'b0) begin n_bad++; $display("FAIL idle_oe: got %b want 0", vme_data_oe); end
        n_cmp++; if (local_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", local_busy); end
        end_iack;
        wait_release(seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL idle_release: got %b want 1", seen); end
    endtask

    task automatic test_busy_reject;
        logic hit, pass, seen;
        int oe_n, w;
        logic [7:0] exp;
        request(8'h45);
        exp_q.push_back(8'h45);
        request(8'h99);
        n_cmp++; if (local_busy !== 1'b1) begin n_bad++; $display("FAIL rej_busy: got %b want 1", local_busy); end
        start_iack(LVL);
        wait_resp(hit, pass, oe_n, w);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rej_dtack: got %b want 1", hit); end
        exp = 8'hxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_cmp++; if (vme_data !== exp) begin n_bad++; $display("FAIL rej_data: got %h want %h", vme_data, exp); end
        end_iack;
        wait_ack(seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rej_ack: got %b want 1", seen); end
    endtask

    task automatic test_async_reset;
        logic hit, pass;
        int oe_n, w;
        logic [7:0] exp;
        request(8'hAA);
        exp_q.push_back(8'hAA);
        start_iack(LVL);
        wait_resp(hit, pass, oe_n, w);
        exp = 8'hxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_cmp++; if (vme_data !== exp) begin n_bad++; $display("FAIL ar_data: got %h want %h", vme_data, exp); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (vme_dtack_n !== 1'b1) begin n_bad++; $display("FAIL ar_dtack: got %b want 1", vme_dtack_n); end
        n_cmp++; if (vme_data_oe !== 1'b0) begin n_bad++; $display("FAIL ar_oe: got %b want 0", vme_data_oe); end
        n_cmp++; if (vme_irq_n !== 7'h7F) begin n_bad++; $display("FAIL ar_irq: got %h want 7f", vme_irq_n); end
        n_cmp++; if (local_busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", local_busy); end
        do_reset;
    endtask

`ifdef VME_INTR_RORA_EN
    task automatic test_rora;
        logic hit, pass, seen;
        int oe_n, w;
        logic [7:0] exp;
        request(8'h5A);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        for (int k = 0; k < 2; k++) begin
            start_iack(LVL);
            wait_resp(hit, pass, oe_n, w);
            n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rora_dtack%0d: got %b want 1", k, hit); end
            exp = 8'hxx;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            n_cmp++; if (vme_data !== exp) begin n_bad++; $display("FAIL rora_data%0d: got %h want %h", k, vme_data, exp); end
            n_cmp++; if (vme_irq_n !== 7'h7D) begin n_bad++; $display("FAIL rora_irq%0d: got %h want 7d", k, vme_irq_n); end
            end_iack;
            wait_ack(seen);
            n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rora_ack%0d: got %b want 1", k, seen); end
            @(negedge clk);
        end
        local_clear = 1'b1;
        @(negedge clk);
        local_clear = 1'b0;
        n_cmp++; if (vme_irq_n !== 7'h7F) begin n_bad++; $display("FAIL rora_clear_irq: got %h want 7f", vme_irq_n); end
        n_cmp++; if (local_busy !== 1'b0) begin n_bad++; $display("FAIL rora_clear_busy: got %b want 0", local_busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_level_match;
        do_reset;
        test_level_mismatch;
        do_reset;
        test_idle_pass;
        do_reset;
        test_busy_reject;
        do_reset;
        test_async_reset;
`ifdef VME_INTR_RORA_EN
        test_rora;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
